nios_system_nios2_qsys_1_oci_dct_packer: RTL and testbench

Upstream feeder for the OCI trace test bench. It accumulates 2-bit direct-compressed-trace (DCT) atoms from the CPU trace path into a 30-bit packing buffer (`dct_buffer`, `dct_count`). It emits completed or flushed frames through a valid/ready holding register. It also generates the `test_ending` / `test_has_ended` pair consumed by the test bench.

---
 rtl/nios_system_nios2_qsys_1_oci_dct_packer.sv | 80 ++++++++
 tb/tb_nios_system_nios2_qsys_1_oci_dct_packer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/nios_system_nios2_qsys_1_oci_dct_packer.sv
// nios_system_nios2_qsys_1_oci_dct_packer: packs 2-bit trace atoms into frames with a drain/end handshake.
// Define DCT_DROP_CNT_EN to implement the saturating drop counter.
module nios_system_nios2_qsys_1_oci_dct_packer #(
  parameter int ATOM_W = 2,
  parameter int SLOTS = 15,
  parameter int DROP_W = 8,
  localparam int BW = ATOM_W * SLOTS,
  localparam int CW = $clog2(SLOTS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom,
  input  logic              end_req,
  input  logic              restart,
  output logic [BW-1:0]     dct_buffer,
  output logic [CW-1:0]     dct_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BW-1:0]     out_data,
  output logic [CW-1:0]     out_count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              test_ending,
  output logic              test_has_ended
);
  typedef enum logic [1:0] {RUN, DRAIN, ENDED} state_t;
  state_t state, state_nxt;
  logic full, hf, in_run, move, accept, drop, clr;
  assign full = dct_count == CW'(SLOTS);
  assign hf = !out_valid || out_ready;
  assign in_run = state == RUN;
  assign move = hf && (in_run ? full : (state == DRAIN && dct_count != '0));
  assign accept = in_run && atom_valid && (!full || hf);
  assign drop = in_run && atom_valid && full && !hf;
  assign clr = state == ENDED && restart;
  always_ff @(posedge clk)
    if (!reset_n) state <= RUN;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     state_nxt = end_req ? DRAIN : RUN;
      DRAIN:   state_nxt = (dct_count == '0 && hf) ? ENDED : DRAIN;
      ENDED:   state_nxt = restart ? RUN : ENDED;
      default: state_nxt = RUN;
    endcase
  end
  always_comb begin
    test_ending = state == DRAIN;
    test_has_ended = state == ENDED;
  end
  // A move clears the buffer; a same-cycle atom lands in the freshly cleared slot.
  always_ff @(posedge clk)
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (move) begin
        out_data <= dct_buffer;
        out_count <= dct_count;
      end
      out_valid <= move || (out_valid && !out_ready);
      dct_buffer <= move ? (accept ? {{(BW-ATOM_W){1'b0}}, atom} : '0)
                         : accept ? {dct_buffer[BW-ATOM_W-1:0], atom} : dct_buffer;
      dct_count <= move ? CW'(accept) : dct_count + CW'(accept);
      overflow <= clr ? 1'b0 : (overflow || drop);
    end
`ifdef DCT_DROP_CNT_EN
  always_ff @(posedge clk)
    if (!reset_n || clr) drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_nios_system_nios2_qsys_1_oci_dct_packer.sv
// tb_nios_system_nios2_qsys_1_oci_dct_packer: scoreboard bench; frames are checked by a monitor as they are accepted.
module tb_nios_system_nios2_qsys_1_oci_dct_packer;
  logic clk = 0, reset_n = 0, atom_valid = 0, end_req = 0, restart = 0, out_ready = 0;
  logic [1:0] atom = 0;
  logic [29:0] dct_buffer, out_data;
  logic [3:0] dct_count, out_count;
  logic out_valid, overflow, test_ending, test_has_ended;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0;
  logic [33:0] exp_q[$];
`ifdef DCT_DROP_CNT_EN
  localparam logic [7:0] EXP_DROPS = 8'd3;
`else
  localparam logic [7:0] EXP_DROPS = 8'd0;
`endif

  nios_system_nios2_qsys_1_oci_dct_packer dut (
    .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom(atom),
    .end_req(end_req), .restart(restart), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .overflow(overflow), .drop_cnt(drop_cnt), .test_ending(test_ending), .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [1:0] a);
    atom_valid = 1;
    atom = a;
    repeat (n) tick();
    atom_valid = 0;
  endtask

  // Monitor: every accepted frame must match the oldest expected frame.
  always @(negedge clk)
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_frame", {out_count, out_data[27:0]}, 32'hDEAD_BEEF);
      else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("frame_data", {2'b0, out_data}, {2'b0, e[29:0]});
        chk("frame_count", {28'b0, out_count}, {28'b0, e[33:30]});
      end
    end

  initial begin
    repeat (2) tick();
    chk("rst_count", {28'b0, dct_count}, 0);
    chk("rst_buffer", {2'b0, dct_buffer}, 0);
    chk("rst_flags", {out_valid, overflow, test_ending, test_has_ended}, 0);
    chk("rst_drop", {24'b0, drop_cnt}, 0);
    reset_n = 1;
    // full frame with downstream ready
    out_ready = 1;
    exp_q.push_back({4'd15, 30'h15555555});
    send(15, 2'b01);
    chk("full_count15", {28'b0, dct_count}, 15);
    tick();
    chk("move_valid", {31'b0, out_valid}, 1);
    chk("move_count0", {28'b0, dct_count}, 0);
    tick();
    chk("drained_valid", {31'b0, out_valid}, 0);
    // backpressure, same-cycle move+atom, drops
    out_ready = 0;
    exp_q.push_back({4'd15, 30'h2AAAAAAA});
    exp_q.push_back({4'd15, 30'h3FFFFFFF});
    send(15, 2'b10);
    send(1, 2'b11);
    chk("samecyc_count1", {28'b0, dct_count}, 1);
    chk("samecyc_atom", {30'b0, dct_buffer[1:0]}, 3);
    chk("samecyc_outcount", {28'b0, out_count}, 15);
    send(14, 2'b11);
    send(3, 2'b11);
    chk("held_count15", {28'b0, dct_count}, 15);
    chk("held_data", {2'b0, out_data}, 32'h2AAAAAAA);
    chk("overflow", {31'b0, overflow}, 1);
    chk("drop_cnt", {24'b0, drop_cnt}, {24'b0, EXP_DROPS});
    out_ready = 1;
    tick();
    chk("second_valid", {31'b0, out_valid}, 1);
    chk("second_data", {2'b0, out_data}, 32'h3FFFFFFF);
    tick();
    // partial frame on end-of-test drain
    exp_q.push_back({4'd3, 30'h39});
    send(1, 2'b11);
    send(1, 2'b10);
    end_req = 1;
    send(1, 2'b01);
    end_req = 0;
    chk("drain_ending", {31'b0, test_ending}, 1);
    send(1, 2'b11);
    chk("drain_ignores_atom", {28'b0, dct_count}, 0);
    chk("partial_valid", {31'b0, out_valid}, 1);
    tick();
    chk("ended_flags", {30'b0, test_ending, test_has_ended}, 1);
    chk("ended_keeps_ovf", {31'b0, overflow}, 1);
    restart = 1;
    tick();
    restart = 0;
    chk("restart_flags", {30'b0, test_ending, test_has_ended}, 0);
    chk("restart_ovf", {31'b0, overflow}, 0);
    chk("restart_drop", {24'b0, drop_cnt}, 0);
    // empty drain ends after one edge
    end_req = 1;
    tick();
    end_req = 0;
    chk("empty_drain", {30'b0, test_ending, test_has_ended}, 2);
    tick();
    chk("empty_ended", {30'b0, test_ending, test_has_ended}, 1);
    restart = 1;
    tick();
    restart = 0;
    // reset mid-frame discards everything
    out_ready = 0;
    send(15, 2'b01);
    send(7, 2'b01);
    chk("pre_rst_count", {28'b0, dct_count}, 7);
    chk("pre_rst_valid", {31'b0, out_valid}, 1);
    reset_n = 0;
    tick();
    chk("mid_rst_count", {28'b0, dct_count}, 0);
    chk("mid_rst_flags", {out_valid, overflow, test_ending, test_has_ended}, 0);
    chk("mid_rst_out", {2'b0, out_data}, 0);
    reset_n = 1;
    out_ready = 1;
    repeat (3) tick();
    chk("post_rst_valid", {31'b0, out_valid}, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
